// File: rtl/nanocache_pkg.sv
// Shared types for the NanoCache line server.
//   line_t      : one cache line, eight 32-bit words, word 0 = beat 0
//   srv_state_e : line server sequencing states
package nanocache_pkg;

    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned WORD_W     = 32;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        UPD
    } srv_state_e;

endpackage

// File: rtl/nanocache_line_buf.sv
// Eight-word line register with per-word write enables and a beat-indexed
// word read mux.
//   i_clk, i_rst : clock, synchronous active-high reset (clears the line)
//   i_word_en    : per-word write enable
//   i_wr_line    : write data, word k lands in word k when i_word_en[k]
//   i_sel        : beat index for o_word
//   o_line       : whole registered line
//   o_word       : registered word selected by i_sel
module nanocache_line_buf
    import nanocache_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [LINE_WORDS-1:0] i_word_en,
    input  line_t                 i_wr_line,
    input  logic [2:0]            i_sel,
    output line_t                 o_line,
    output logic [WORD_W-1:0]     o_word
);

    line_t line_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            line_q <= '0;
        end else begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                if (i_word_en[k]) begin
                    line_q[k] <= i_wr_line[k];
                end
            end
        end
    end

    assign o_line = line_q;
    assign o_word = line_q[i_sel];

endmodule

// File: rtl/nanocache_line_server.sv
// Memory-side responder for the NanoCache miss/writeback interface.
// Sequences line reads, victim writes and background writebacks as eight
// word beats against a single-port SRAM and returns fills as one line.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_flush               : aborts a pending or active read
//   i_miss_rden/i_miss_wren : level line read / victim write, held until o_miss_resp
//   i_wb_wren             : one-cycle writeback request, dropped if not granted
//   i_miss_addr           : line address, i_miss_wdata : write line
//   o_miss_resp           : pulse one cycle after a miss request is accepted
//   o_wb_gnt              : writeback accepted this cycle (combinational)
//   o_upd_valid/o_upd_rdata : fill pulse and filled line
//   o_sram_*/i_sram_rdata : word SRAM port, read data one cycle after strobe
module nanocache_line_server
    import nanocache_pkg::*;
#(
    parameter int unsigned SRAM_AW = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_miss_rden,
    input  logic               i_miss_wren,
    input  logic               i_wb_wren,
    input  logic [31:0]        i_miss_addr,
    input  line_t              i_miss_wdata,
    output logic               o_miss_resp,
    output logic               o_wb_gnt,
    output logic               o_upd_valid,
    output line_t              o_upd_rdata,
    output logic               o_sram_rden,
    output logic               o_sram_wren,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [31:0]        o_sram_wdata,
    output logic [3:0]         o_sram_wstrb,
    input  logic [31:0]        i_sram_rdata
);

    localparam int unsigned LINE_AW = SRAM_AW - 3;

    srv_state_e         state_q, state_d;
    logic [2:0]         beat_q, beat_d;
    logic               drain_q, drain_d;   // RD: all beats issued, last word in flight
    logic [LINE_AW-1:0] line_q, line_d;
    logic               resp_q, resp_d;
    logic               cap_en_q, cap_en_d; // SRAM read data valid this cycle
    logic [2:0]         cap_idx_q, cap_idx_d;
    logic               wdata_load;
    logic               wb_gnt;

    logic [LINE_WORDS-1:0] fill_en;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     unused_fill_word;
    line_t                 unused_wr_line;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^i_miss_addr[31:LINE_AW];

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        line_d     = line_q;
        resp_d     = 1'b0;
        cap_en_d   = 1'b0;
        cap_idx_d  = beat_q;
        wdata_load = 1'b0;
        wb_gnt     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_miss_wren) begin
                    state_d    = WR;
                    line_d     = i_miss_addr[LINE_AW-1:0];
                    resp_d     = 1'b1;
                    wdata_load = 1'b1;
                end else if (i_miss_rden && !i_flush) begin
                    state_d = RD;
                    line_d  = i_miss_addr[LINE_AW-1:0];
                    resp_d  = 1'b1;
                end else if (i_wb_wren) begin
                    state_d    = WR;
                    line_d     = i_miss_addr[LINE_AW-1:0];
                    wdata_load = 1'b1;
                    wb_gnt     = 1'b1;
                end
            end
            WR: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (i_flush) begin
                    state_d = IDLE;
                    beat_d  = 3'd0;
                    drain_d = 1'b0;
                end else if (drain_q) begin
                    state_d = UPD;
                    drain_d = 1'b0;
                end else begin
                    cap_en_d  = 1'b1;
                    cap_idx_d = beat_q;
                    beat_d    = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        drain_d = 1'b1;
                    end
                end
            end
            UPD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            beat_q    <= 3'd0;
            drain_q   <= 1'b0;
            line_q    <= '0;
            resp_q    <= 1'b0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            line_q    <= line_d;
            resp_q    <= resp_d;
            cap_en_q  <= cap_en_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    // Fill buffer: one word per returning read beat.
    assign fill_en = cap_en_q ? (LINE_WORDS'(1) << cap_idx_q) : '0;

    nanocache_line_buf u_fill_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_word_en (fill_en),
        .i_wr_line ({LINE_WORDS{i_sram_rdata}}),
        .i_sel     (3'd0),
        .o_line    (o_upd_rdata),
        .o_word    (unused_fill_word)
    );

    // Write buffer: whole line captured at acceptance, streamed out by beat.
    nanocache_line_buf u_wr_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_word_en ({LINE_WORDS{wdata_load}}),
        .i_wr_line (i_miss_wdata),
        .i_sel     (beat_q),
        .o_line    (unused_wr_line),
        .o_word    (wr_word)
    );

    assign o_sram_rden  = (state_q == RD) && !drain_q;
    assign o_sram_wren  = (state_q == WR);
    assign o_sram_addr  = (o_sram_rden || o_sram_wren) ? {line_q, beat_q} : '0;
    assign o_sram_wdata = o_sram_wren ? wr_word : '0;
    assign o_sram_wstrb = o_sram_wren ? 4'hf : 4'h0;

    // A flush in the response cycle of a read cancels the response too.
    assign o_miss_resp = resp_q && !(i_flush && (state_q == RD));
    assign o_upd_valid = (state_q == UPD) && !i_flush;
    assign o_wb_gnt    = wb_gnt && !i_rst;

endmodule

// File: tb/tb_nanocache_line_server.sv
module tb_nanocache_line_server;
    import nanocache_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic        i_miss_rden;
    logic        i_miss_wren;
    logic        i_wb_wren;
    logic [31:0] i_miss_addr;
    line_t       i_miss_wdata;
    logic        o_miss_resp;
    logic        o_wb_gnt;
    logic        o_upd_valid;
    line_t       o_upd_rdata;
    logic        o_sram_rden;
    logic        o_sram_wren;
    logic [15:0] o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic [3:0]  o_sram_wstrb;
    logic [31:0] i_sram_rdata;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } sram_op_t;

    sram_op_t    sram_q[$];
    line_t       fill_q[$];
    logic [31:0] mem [0:65535];

    nanocache_line_server #(.SRAM_AW(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_miss_rden  (i_miss_rden),
        .i_miss_wren  (i_miss_wren),
        .i_wb_wren    (i_wb_wren),
        .i_miss_addr  (i_miss_addr),
        .i_miss_wdata (i_miss_wdata),
        .o_miss_resp  (o_miss_resp),
        .o_wb_gnt     (o_wb_gnt),
        .o_upd_valid  (o_upd_valid),
        .o_upd_rdata  (o_upd_rdata),
        .o_sram_rden  (o_sram_rden),
        .o_sram_wren  (o_sram_wren),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_wstrb (o_sram_wstrb),
        .i_sram_rdata (i_sram_rdata)
    );

    always #5 i_clk = ~i_clk;

    // SRAM model: registered read data, write on strobe.
    always @(posedge i_clk) begin
        if (o_sram_rden === 1'b1) i_sram_rdata <= mem[o_sram_addr];
        if (o_sram_wren === 1'b1) mem[o_sram_addr] <= o_sram_wdata;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard: every SRAM strobe and every fill pulse must match the next expectation.
    always @(negedge i_clk) begin
        if (o_sram_rden === 1'b1 || o_sram_wren === 1'b1) begin
            if (sram_q.size() == 0) begin
                check("sram_unexpected", {o_sram_rden, o_sram_wren}, 2'b00);
            end else begin
                sram_op_t e;
                e = sram_q.pop_front();
                check("sram_op", {o_sram_wren, o_sram_addr, o_sram_wren ? o_sram_wdata : 32'h0}, e);
                if (o_sram_wren === 1'b1) check("sram_wstrb", o_sram_wstrb, 4'hf);
            end
        end
        if (o_upd_valid === 1'b1) begin
            if (fill_q.size() == 0) check("upd_unexpected", o_upd_valid, 1'b0);
            else check("upd_data", o_upd_rdata, fill_q.pop_front());
        end
    end

    function automatic line_t mk(input logic [31:0] base);
        line_t l;
        for (int k = 0; k < 8; k++) l[k] = base + 32'(k);
        return l;
    endfunction

    function automatic line_t mem_line(input int base);
        line_t l;
        for (int k = 0; k < 8; k++) l[k] = mem[base + k];
        return l;
    endfunction

    task automatic push_reads(input logic [15:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) sram_q.push_back({1'b0, base + 16'(k), 32'h0});
    endtask

    task automatic push_writes(input logic [15:0] base, input line_t d, input int cnt);
        for (int k = 0; k < cnt; k++) sram_q.push_back({1'b1, base + 16'(k), d[k]});
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Wait for the fill pulse, bounded, and check it came after exp_n cycles.
    task automatic wait_upd(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            next_cycle();
            @(negedge i_clk);
            n++;
        end while (o_upd_valid !== 1'b1 && n < 30);
        check(tag, n, exp_n);
    endtask

    task automatic do_read(input string tag, input logic [31:0] line, input line_t exp_fill);
        int n;
        i_miss_addr = line;
        i_miss_rden = 1'b1;
        push_reads(16'(line << 3), 8);
        fill_q.push_back(exp_fill);
        n = 0;
        do begin
            next_cycle();
            @(negedge i_clk);
            n++;
            if (n == 1) begin
                check({tag, "_resp"}, o_miss_resp, 1'b1);
                check({tag, "_rden"}, o_sram_rden, 1'b1);
                i_miss_rden = 1'b0;
            end
            if (n == 9) check({tag, "_drain"}, o_sram_rden, 1'b0);
        end while (o_upd_valid !== 1'b1 && n < 30);
        check({tag, "_lat"}, n, 10);
    endtask

    task automatic do_write(input string tag, input logic [31:0] line, input line_t d,
                            input logic is_wb);
        i_miss_addr  = line;
        i_miss_wdata = d;
        if (is_wb) i_wb_wren = 1'b1;
        else i_miss_wren = 1'b1;
        push_writes(16'(line << 3), d, 8);
        @(negedge i_clk);
        check({tag, "_gnt"}, o_wb_gnt, is_wb);
        for (int n = 1; n <= 9; n++) begin
            next_cycle();
            if (n == 1) begin
                i_wb_wren    = 1'b0;
                i_miss_wdata = mk(32'hDEAD0000);
            end
            @(negedge i_clk);
            if (n == 1) begin
                check({tag, "_resp"}, o_miss_resp, !is_wb);
                check({tag, "_wren"}, o_sram_wren, 1'b1);
                i_miss_wren = 1'b0;
            end
            if (n == 9) check({tag, "_idle"}, o_sram_wren, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t exp6;
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        for (int k = 0; k < 8; k++) begin
            mem[16'h200 + k] = 32'h1000 + k;
            mem[16'h100 + k] = 32'h2000 + k;
            mem[16'h030 + k] = 32'h3000 + k;
            mem[16'h040 + k] = 32'h4000 + k;
            mem[16'h048 + k] = 32'h4800 + k;
            mem[16'h090 + k] = 32'hEE00 + k;
        end
        i_sram_rdata = 32'h0;
        i_rst = 1'b1;
        i_flush = 1'b0;
        i_miss_rden = 1'b0;
        i_miss_wren = 1'b0;
        i_wb_wren = 1'b0;
        i_miss_addr = 32'h0;
        i_miss_wdata = '0;
        next_cycle();
        next_cycle();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_strobes", {o_sram_rden, o_sram_wren, o_sram_wstrb}, 6'h0);
        check("rst_addr", o_sram_addr, 16'h0);
        check("rst_pulses", {o_miss_resp, o_upd_valid, o_wb_gnt}, 3'b000);
        check("rst_rdata", o_upd_rdata, 256'h0);

        // Read miss of line 0x40.
        next_cycle();
        do_read("rd1", 32'h40, mk(32'h1000));
        next_cycle();
        @(negedge i_clk);
        check("rd1_pulse_end", o_upd_valid, 1'b0);
        check("rd1_hold", o_upd_rdata, mk(32'h1000));

        // Victim write of line 0x10 then read of line 0x20 held behind it.
        next_cycle();
        i_miss_addr = 32'h10;
        i_miss_wdata = mk(32'hA0);
        i_miss_wren = 1'b1;
        push_writes(16'h80, mk(32'hA0), 8);
        next_cycle();
        @(negedge i_clk);
        check("vw_resp", o_miss_resp, 1'b1);
        i_miss_wren = 1'b0;
        i_miss_rden = 1'b1;
        i_miss_addr = 32'h20;
        i_miss_wdata = mk(32'h5555);
        push_reads(16'h100, 8);
        fill_q.push_back(mk(32'h2000));
        for (int n = 2; n <= 9; n++) begin
            next_cycle();
            @(negedge i_clk);
            if (n == 9) check("vw_gap", {o_sram_rden, o_sram_wren, o_miss_resp}, 3'b000);
        end
        next_cycle();
        @(negedge i_clk);
        check("vw_rd_start", {o_sram_rden, o_miss_resp, o_sram_addr}, {2'b11, 16'h100});
        i_miss_rden = 1'b0;
        wait_upd("vw_rd_lat", 9);
        check("vw_mem", mem_line(16'h80), mk(32'hA0));

        // Background writeback of line 0x05, no miss response.
        next_cycle();
        do_write("wb", 32'h05, mk(32'hB0), 1'b1);
        check("wb_mem", mem_line(16'h28), mk(32'hB0));
        check("wb_rdata_hold", o_upd_rdata, mk(32'h2000));

        // Writeback pulse during a read is dropped.
        next_cycle();
        i_miss_addr = 32'h06;
        i_miss_rden = 1'b1;
        push_reads(16'h30, 8);
        fill_q.push_back(mk(32'h3000));
        next_cycle();
        @(negedge i_clk);
        check("wbrd_resp", o_miss_resp, 1'b1);
        i_miss_rden = 1'b0;
        next_cycle();
        next_cycle();
        i_wb_wren = 1'b1;
        i_miss_wdata = mk(32'hBAD0);
        @(negedge i_clk);
        check("wbrd_gnt", o_wb_gnt, 1'b0);
        next_cycle();
        i_wb_wren = 1'b0;
        @(negedge i_clk);
        wait_upd("wbrd_lat", 6);

        // All three requests in one cycle: write first, then the read.
        next_cycle();
        i_miss_addr = 32'h11;
        i_miss_wdata = mk(32'hC0);
        i_miss_wren = 1'b1;
        i_miss_rden = 1'b1;
        i_wb_wren = 1'b1;
        push_writes(16'h88, mk(32'hC0), 8);
        push_reads(16'h88, 8);
        fill_q.push_back(mk(32'hC0));
        @(negedge i_clk);
        check("tri_gnt", o_wb_gnt, 1'b0);
        next_cycle();
        i_wb_wren = 1'b0;
        @(negedge i_clk);
        check("tri_wr", {o_miss_resp, o_sram_wren}, 2'b11);
        i_miss_wren = 1'b0;
        for (int n = 2; n <= 9; n++) begin
            next_cycle();
            @(negedge i_clk);
            if (n == 9) check("tri_gap", {o_sram_rden, o_miss_resp}, 2'b00);
        end
        next_cycle();
        @(negedge i_clk);
        check("tri_rd_start", {o_sram_rden, o_miss_resp}, 2'b11);
        i_miss_rden = 1'b0;
        wait_upd("tri_lat", 9);

        // Flush at T+4 of a read, new read at T+5.
        next_cycle();
        i_miss_addr = 32'h08;
        i_miss_rden = 1'b1;
        push_reads(16'h40, 4);
        next_cycle();
        @(negedge i_clk);
        check("fl_resp", o_miss_resp, 1'b1);
        i_miss_rden = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        i_flush = 1'b1;
        @(negedge i_clk);
        check("fl_rden_t4", o_sram_rden, 1'b1);
        next_cycle();
        i_flush = 1'b0;
        i_miss_addr = 32'h09;
        i_miss_rden = 1'b1;
        push_reads(16'h48, 8);
        fill_q.push_back(mk(32'h4800));
        @(negedge i_clk);
        check("fl_t5_quiet", {o_sram_rden, o_sram_wren, o_upd_valid}, 3'b000);
        next_cycle();
        @(negedge i_clk);
        check("fl_rd2_start", {o_miss_resp, o_sram_rden, o_sram_addr}, {2'b11, 16'h48});
        i_miss_rden = 1'b0;
        wait_upd("fl_rd2_lat", 9);

        // Reset at T+3 of a write, then a read of the partly written line.
        next_cycle();
        i_miss_addr = 32'h12;
        i_miss_wdata = mk(32'hD0);
        i_miss_wren = 1'b1;
        push_writes(16'h90, mk(32'hD0), 3);
        next_cycle();
        @(negedge i_clk);
        check("rw_resp", o_miss_resp, 1'b1);
        i_miss_wren = 1'b0;
        next_cycle();
        next_cycle();
        i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rw_strobes", {o_sram_rden, o_sram_wren, o_sram_wstrb}, 6'h0);
        check("rw_bus", {o_sram_addr, o_sram_wdata}, 48'h0);
        check("rw_pulses", {o_miss_resp, o_upd_valid, o_wb_gnt}, 3'b000);
        check("rw_rdata", o_upd_rdata, 256'h0);
        exp6 = mk(32'hEE00);
        exp6[0] = 32'hD0;
        exp6[1] = 32'hD1;
        exp6[2] = 32'hD2;
        next_cycle();
        do_read("rw_rd", 32'h12, exp6);

        next_cycle();
        next_cycle();
        @(negedge i_clk);
        check("sram_q_empty", sram_q.size(), 0);
        check("fill_q_empty", fill_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nanocache_line_server.md
# nanocache_line_server

Memory-side responder for the NanoCache miss/writeback interface. It accepts line reads (cache misses), dirty-victim line writes and background writebacks from the cache search stage. Each request is sequenced as eight 32-bit beats against a single-port, word-wide SRAM. Fills are returned to the cache as one 256-bit update. The block sits between the cache search logic and the data SRAM.

## Interface
Parameters:
- SRAM_AW, 16: SRAM word-address width. Line index = `i_miss_addr[SRAM_AW-4:0]`.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_flush  in  1  pipeline flush; aborts a pending/active read
- i_miss_rden  in  1  line-read request, level, held until o_miss_resp
- i_miss_wren  in  1  victim line-write request, level, held until o_miss_resp
- i_wb_wren  in  1  background writeback request, one-cycle pulse
- i_miss_addr  in  32  line address (byte address >> 5)
- i_miss_wdata  in  8x32  line data for write requests, word 0 = beat 0
- o_miss_resp  out  1  one-cycle pulse: miss read/write accepted
- o_wb_gnt  out  1  combinational: writeback accepted this cycle
- o_upd_valid  out  1  one-cycle pulse: o_upd_rdata holds the filled line
- o_upd_rdata  out  8x32  filled line
- o_sram_rden  out  1  SRAM read strobe; data returns next cycle
- o_sram_wren  out  1  SRAM write strobe
- o_sram_addr  out  SRAM_AW  word address = {line, beat[2:0]}
- o_sram_wdata  out  32  write word
- o_sram_wstrb  out  4  byte strobes; always 4'hf when writing
- i_sram_rdata  in  32  read data, valid the cycle after o_sram_rden

## Operation
- States:
  - IDLE: accepts requests.
  - WR: 8 write beats.
  - RD: 8 read beats plus 1 cycle of data drain.
  - UPD: o_upd_valid.
- Acceptance happens only in IDLE. Priority is i_miss_wren > i_miss_rden > i_wb_wren.
- A read is not accepted in a cycle with i_flush=1.
- `o_wb_gnt = i_wb_wren & IDLE & ~i_miss_wren & ~(i_miss_rden & ~i_flush) & ~i_rst`.
- A write back that is not granted is dropped. The cache re-pulses it.
- On acceptance, the block captures line address, kind (miss/wb) and, for writes, all 256 bits of i_miss_wdata. Later changes on the inputs are ignored.
- A 3-bit beat counter runs 0..7 and wraps to 0 at the end of every transaction.
- Read data is written into buffer word k at the cycle after beat k is issued.
- Writes (miss or wb) always complete; i_flush has no effect on them.
- A victim write followed by the cache's read is served strictly in order. The read is accepted no earlier than the cycle after the last write beat.
- Reset values: all outputs 0, state IDLE, counter 0, o_upd_rdata 0.

## Timing
Request accepted in cycle T.
- o_miss_resp: pulses at T+1 for miss read/write. It does not pulse for writebacks.
- Writes:
  - o_sram_wren high T+1..T+8, beat k at T+1+k.
  - Back in IDLE at T+9, where a new request can be accepted.
- Reads:
  - o_sram_rden high T+1..T+8.
  - Data captured T+2..T+9.
  - o_upd_valid is a 1-cycle pulse at T+10.
  - IDLE at T+11.
- o_upd_rdata: updates only at beat capture and holds its value otherwise.
- Flush during RD/UPD (T+1..T+10):
  - SRAM strobes drop the next cycle.
  - o_miss_resp and o_upd_valid are suppressed from that cycle on.
  - State returns to IDLE the next cycle.
- Reset mid-transaction: the next cycle is IDLE with all strobes 0. A partial SRAM line write is not rolled back.

## Structure
- Shared package `nanocache_pkg`:
  - `line_t` (8x32 logic)
  - LINE_WORDS = 8
  - `srv_state_e` enum {IDLE, WR, RD, UPD}
- Sub-module `nanocache_line_buf`: 8x32 register, write-enable by beat index, beat-indexed mux for the write word. The FSM, counter and handshakes stay in the top.

## Test plan
- Read miss, `i_miss_addr=0x40`, SRAM words 0x200..0x207 preloaded 0x1000+k -> o_miss_resp at T+1, reads 0x200..0x207 at T+1..T+8, o_upd_valid at T+10 with word k = 0x1000+k.
- Victim write, line 0x10, data 0xA0+k, then rden for line 0x20 right after the resp -> SRAM 0x80..0x87 = 0xA0..0xA7, first read strobe at T+10 for address 0x100.
- Writeback pulse in IDLE, line 0x05 -> o_wb_gnt same cycle, writes 0x28..0x2F at T+1..T+8, no o_miss_resp. Writeback pulse during RD -> o_wb_gnt=0, no SRAM activity.
- Same-cycle i_miss_wren, i_miss_rden, i_wb_wren -> write served first, o_wb_gnt=0, read accepted at T+9.
- Flush at T+4 of a read -> no o_upd_valid, strobes 0 at T+5, IDLE at T+5. A read request at T+5 is accepted and completes normally.
- i_rst at T+3 of a write -> all outputs 0 at T+4, IDLE; a new read after reset completes in 10 cycles.
